mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single external memory bridge between the IF-stage instruction fetch port and the
//  MEM-stage data port. Serialises bus transactions, holds each request stable until the bridge
//  acknowledges it, and returns read data to the owner. Generates per-port stall signals for the
//  stall detector. Drops fetch responses killed by a branch-correct flush. Bounds every
//  transaction with a timeout.
// PARAMETERS
//  ADDR_W         32   address width
//  DATA_W         32   data width
//  STARVE_MAX     4    consecutive data grants allowed while a fetch is pending
//  TIMEOUT_CYCLES 256  bus cycles without bus_ack before abort (>=2)
// PORTS
//  clk        in   1       pipeline clock
//  rst        in   1       synchronous, active-high reset
//  if_req     in   1       fetch request; held until if_valid
//  if_addr    in   ADDR_W  fetch address
//  if_flush   in   1       branch-correct flush of the IF stage
//  if_rdata   out  DATA_W  fetched word
//  if_valid   out  1       one-cycle pulse: if_rdata valid
//  if_stall   out  1       fetch waiting on the bus
//  dm_req     in   1       data request; held until dm_valid
//  dm_we      in   1       1 = store, 0 = load
//  dm_be      in   4       byte enables
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  store data
//  dm_rdata   out  DATA_W  load data
//  dm_valid   out  1       one-cycle pulse: access complete
//  dm_stall   out  1       data access waiting on the bus
//  bus_req    out  1       bridge request; held until bus_ack
//  bus_we     out  1       bridge write
//  bus_be     out  4       bridge byte enables
//  bus_addr   out  ADDR_W  bridge address
//  bus_wdata  out  DATA_W  bridge write data
//  bus_rdata  in   DATA_W  bridge read data; sampled only when bus_ack=1
//  bus_ack    in   1       bridge completes the current request this cycle
//  bus_timeout out 1       one-cycle pulse: transaction aborted
// BEHAVIOUR
//  Reset:
//   - all outputs 0; state IDLE; starvation counter and timeout counter 0.
//   - rst mid-transaction abandons it immediately: bus_req=0 next cycle, no valid pulse.
//  FSM states: IDLE, INST, DATA, INST_DROP.
//  IDLE grant, evaluated each cycle:
//   - dm_req wins over if_req, unless starve_cnt==STARVE_MAX and if_req=1; then fetch wins.
//   - if_req with if_flush=1 in the same cycle is not granted.
//   - On grant: latch addr/we/be/wdata into bus_* registers; bus_req=1 from the next cycle.
//   - Fetch bus_we=0, bus_be=4'hF.
//   - starve_cnt increments on a data grant while if_req=1 (saturates). It clears on a fetch
//     grant or whenever if_req=0.
//  INST / DATA:
//   - bus_* stable while bus_req=1.
//   - On bus_ack: bus_req=0; owner rdata<=bus_rdata; owner valid pulses next cycle; go to IDLE.
//   - Stores also pulse dm_valid; dm_rdata is don't-care for stores.
//  Flush:
//   - if_flush in INST, including the ack cycle, moves the FSM to INST_DROP, or straight to
//     IDLE if ack is present that cycle. if_valid is never pulsed for a flushed fetch.
//   - INST_DROP waits for bus_ack and then goes to IDLE. The bus transaction is always completed.
//   - if_flush while DATA is in progress has no effect.
//  Latency: request seen at cycle t, bus_req at t+1, earliest ack at t+1, valid at t+2.
//   The next grant is no earlier than the valid cycle, so there is at most one outstanding
//   transaction.
//  Stalls, combinational from registers and inputs:
//   - if_stall = if_req & ~if_valid.
//   - dm_stall = dm_req & ~dm_valid.
//  Timeout:
//   - tmo_cnt counts cycles with bus_req=1 and resets on each grant.
//   - When it reaches TIMEOUT_CYCLES-1 without ack: bus_req=0; bus_timeout pulses; owner valid
//     pulses with rdata=0 (none for INST_DROP); go to IDLE.
//   - An ack in the same cycle takes precedence over the timeout.
// STRUCTURE
//  Package mem_arb_pkg:
//   - arb_state_t enum {IDLE, INST, DATA, INST_DROP}
//   - arb_owner_t enum {OWN_NONE, OWN_INST, OWN_DATA}
//   - FETCH_BE constant 4'hF
//  Sub-module mem_arb_starve: starvation counter plus fetch-priority flag; STARVE_MAX parameter.
//  Top: FSM, request latch, response registers, timeout counter.
// TESTING
//  1 Single fetch, ack 1 cycle after bus_req, bus_rdata=32'h2402000A
//    -> if_valid pulse at t+2 with that data; bus_we=0, bus_be=F.
//  2 if_req and dm_req both asserted (store, addr 0x10, be=4'h3)
//    -> data granted first; bus_we=1 stays stable across a 3-cycle ack delay; fetch granted after dm_valid.
//  3 dm_req held continuously with if_req pending, STARVE_MAX=4
//    -> 4 data grants, then 1 fetch grant, then data grants resume.
//  4 if_flush 1 cycle after a fetch grant, ack 3 cycles later
//    -> bus_req held until ack, no if_valid, next grant in the cycle after ack.
//  5 No ack, TIMEOUT_CYCLES=8
//    -> bus_req drops after 8 cycles; bus_timeout and dm_valid pulse with dm_rdata=0.
//  6 rst asserted while DATA is waiting
//    -> next cycle bus_req=0, all outputs 0; a new request afterwards completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INST,
    DATA,
    INST_DROP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } arb_owner_t;

  localparam logic [3:0] FETCH_BE = 4'hF;

  // A dropped fetch still occupies the bus but has nobody to answer.
  function automatic arb_owner_t state_owner(input arb_state_t s);
    case (s)
      INST:    return OWN_INST;
      DATA:    return OWN_DATA;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - counts back-to-back data grants taken while a fetch waits
module mem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic grant_inst,
  input  logic grant_data,
  output logic fetch_pri
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign fetch_pri = (starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst || !if_req || grant_inst) begin
      starve_cnt <= '0;
    end else if (grant_data && !fetch_pri) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bridge between the fetch and data ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  arb_state_t        state;
  arb_owner_t        owner;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              fetch_pri;
  logic              grant_inst;
  logic              grant_data;
  logic              ack;
  logic              tmo_hit;
  logic [DATA_W-1:0] resp;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  assign owner   = state_owner(state);
  assign ack     = bus_req & bus_ack;
  assign tmo_hit = bus_req & ~bus_ack & (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign resp    = ack ? bus_rdata : '0;

  // A fetch killed in the same cycle never reaches the bus.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state == IDLE) begin
      if (if_req && !if_flush && (!dm_req || fetch_pri)) begin
        grant_inst = 1'b1;
      end else if (dm_req) begin
        grant_data = 1'b1;
      end
    end
  end

  mem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .grant_inst(grant_inst),
    .grant_data(grant_data),
    .fetch_pri (fetch_pri)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_be      <= 4'h0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      if_valid    <= 1'b0;
      if_rdata    <= '0;
      dm_valid    <= 1'b0;
      dm_rdata    <= '0;
      bus_timeout <= 1'b0;
    end else begin
      if_valid    <= 1'b0;
      dm_valid    <= 1'b0;
      bus_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (grant_inst) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_be    <= FETCH_BE;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            state     <= INST;
          end else if (grant_data) begin
            bus_req   <= 1'b1;
            bus_we    <= dm_we;
            bus_be    <= dm_be;
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
            state     <= DATA;
          end
        end
        default: begin
          if (ack || tmo_hit) begin
            bus_req     <= 1'b0;
            bus_timeout <= tmo_hit;
            state       <= IDLE;
            if (owner == OWN_DATA) begin
              dm_valid <= 1'b1;
              dm_rdata <= resp;
            end else if (owner == OWN_INST && !if_flush) begin
              if_valid <= 1'b1;
              if_rdata <= resp;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            // The bridge transaction still runs to completion; only the answer is dropped.
            if (owner == OWN_INST && if_flush) begin
              state <= INST_DROP;
            end
          end
        end
      endcase
    end
  end

endmodule
